// File: rtl/fifo_rd_unpacker_if.sv
// Bus bundle for fifo_rd_unpacker: FIFO read port on one side, beat stream on the other.
// master = unpacker side, slave = FIFO/downstream side.
interface fifo_rd_unpacker_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 8
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [IN_W-1:0]  fifo_data;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_rd_en, out_data, out_valid, out_last
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_last
    );
endinterface

// File: rtl/fifo_rd_unpacker.sv
// Pops IN_W-bit words from the async FIFO read port and streams them out as OUT_W-bit beats.
// Optional statistics counters (word_cnt, stall_cnt) are built when UNPACK_STATS_EN is defined.
module fifo_rd_unpacker #(
    parameter int unsigned IN_W      = 32,
    parameter int unsigned OUT_W     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_rd_unpacker_if.master       bus,
    output logic                     busy
`ifdef UNPACK_STATS_EN
    ,
    output logic [CNT_W-1:0]         word_cnt,
    output logic [CNT_W-1:0]         stall_cnt
`endif
);

    localparam int unsigned RATIO  = IN_W / OUT_W;
    localparam int unsigned BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    if ((IN_W % OUT_W) != 0 || RATIO == 0 || CNT_W == 0) begin : g_bad_cfg
        $error("fifo_rd_unpacker: IN_W must be a non-zero multiple of OUT_W and CNT_W > 0");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               fifo_rd_en_q, fifo_rd_en_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [IN_W-1:0]    hold_q, hold_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               busy_q, busy_d;

    logic               xfer_c;
    logic               last_xfer_c;
    logic [BEAT_W-1:0]  next_beat_c;

    function automatic logic [OUT_W-1:0] slice(input logic [IN_W-1:0]   word,
                                               input logic [BEAT_W-1:0] beat);
        int unsigned lane;
        lane = MSB_FIRST ? (RATIO - 1 - 32'(beat)) : 32'(beat);
        return OUT_W'(word >> (lane * OUT_W));
    endfunction

    assign xfer_c      = out_valid_q && bus.out_ready;
    assign last_xfer_c = xfer_c && (beat_q == LAST_BEAT);
    assign next_beat_c = beat_q + BEAT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fifo_rd_en_q) state_d = WAIT;
            WAIT:    state_d = SEND;
            SEND:    if (last_xfer_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The read strobe is registered one cycle ahead: it is decided in IDLE, or on the
    // final beat transfer so back-to-back words cost only the IDLE+WAIT bubble.
    always_comb begin
        fifo_rd_en_d = 1'b0;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        hold_d       = hold_q;
        beat_d       = beat_q;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                fifo_rd_en_d = !fifo_rd_en_q && !bus.fifo_empty;
            end
            WAIT: begin
                hold_d      = bus.fifo_data;
                beat_d      = '0;
                out_valid_d = 1'b1;
                out_data_d  = slice(bus.fifo_data, BEAT_W'(0));
                out_last_d  = (LAST_BEAT == '0);
            end
            SEND: begin
                if (last_xfer_c) begin
                    out_valid_d  = 1'b0;
                    out_last_d   = 1'b0;
                    out_data_d   = '0;
                    beat_d       = '0;
                    fifo_rd_en_d = !bus.fifo_empty;
                end else if (xfer_c) begin
                    beat_d     = next_beat_c;
                    out_data_d = slice(hold_q, next_beat_c);
                    out_last_d = (next_beat_c == LAST_BEAT);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_rd_en_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            hold_q       <= '0;
            beat_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            fifo_rd_en_q <= fifo_rd_en_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            hold_q       <= hold_d;
            beat_q       <= beat_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.fifo_rd_en = fifo_rd_en_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_data   = out_data_q;
    assign busy           = busy_q;

`ifdef UNPACK_STATS_EN
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters; only reset clears them.
    always_comb begin
        word_cnt_d  = word_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (last_xfer_c && (word_cnt_q != '1)) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
        if (out_valid_q && !bus.out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
